cmd_dispatcher: RTL and testbench

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/frontend_command_definition_pkg.sv | 28 ++
 rtl/cmd_dispatcher.sv | 100 ++++++++++
 tb/tb_cmd_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frontend_command_definition_pkg.sv
// rtl/frontend_command_definition_pkg.sv - frontend command word layout shared by FIFO, dispatcher and bank controllers
package frontend_command_definition_pkg;

  localparam int CMD_BITS = 32;
  localparam int OP_W     = 2;
  localparam int BANK_W   = 2;
  localparam int ROW_W    = 14;
  localparam int COL_W    = 10;
  localparam int ID_W     = 4;
  localparam int OP_LSB   = 30;
  localparam int BANK_LSB = 28;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_REFRESH = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ID_W-1:0]   id;
  } cmd_t;

endpackage

// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - pops frontend commands and hands them to bank controllers
module cmd_dispatcher
  import frontend_command_definition_pkg::*;
#(
  parameter int NUM_BANK  = 4,
  parameter int CMD_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CMD_WIDTH-1:0] i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  output logic [NUM_BANK-1:0]  o_bank_valid,
  output logic [CMD_WIDTH-1:0] o_bank_cmd,
  input  logic [NUM_BANK-1:0]  i_bank_ready,
  output logic                 o_busy,
  output logic [15:0]          o_issue_cnt,
  output logic [7:0]           o_drop_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, REF} state_e;

  // Bank field is 2 bits; fold it onto the banks actually present.
  localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANK - 1);

  state_e               r_state;
  logic [CMD_WIDTH-1:0] r_cmd;
  logic [NUM_BANK-1:0]  r_bank_valid;
  logic [NUM_BANK-1:0]  r_ack_mask;
  logic [15:0]          r_issue_cnt;
  logic [7:0]           r_drop_cnt;

  op_e                  w_head_op;
  logic [BANK_W-1:0]    w_head_bank;
  logic [NUM_BANK-1:0]  w_head_sel;
  logic [NUM_BANK-1:0]  w_acks;
  logic                 w_hs;
  logic                 w_ref_done;
  logic                 w_pop;

  assign w_head_op   = op_e'(i_fifo_data[OP_LSB +: OP_W]);
  assign w_head_bank = i_fifo_data[BANK_LSB +: BANK_W] & BANK_MASK;
  assign w_head_sel  = NUM_BANK'(1) << w_head_bank;
  assign w_acks      = r_bank_valid & i_bank_ready;
  assign w_hs        = (r_state == ISSUE) && (|w_acks);
  assign w_ref_done  = (r_state == REF) && ((r_ack_mask | w_acks) == '1);
  assign w_pop       = !i_fifo_empty && ((r_state == IDLE) || w_hs || w_ref_done);

  // Gating with reset keeps the FIFO from losing a head while we are held in reset.
  assign o_fifo_rd_en = w_pop && i_rst_n;
  assign o_bank_valid = r_bank_valid;
  assign o_bank_cmd   = r_cmd;
  assign o_busy       = (r_state != IDLE);
  assign o_issue_cnt  = r_issue_cnt;
  assign o_drop_cnt   = r_drop_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cmd        <= '0;
      r_bank_valid <= '0;
      r_ack_mask   <= '0;
      r_issue_cnt  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_hs) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
      if (w_pop) begin
        r_cmd      <= i_fifo_data;
        r_ack_mask <= '0;
        case (w_head_op)
          OP_READ, OP_WRITE: begin
            r_state      <= ISSUE;
            r_bank_valid <= w_head_sel;
          end
          OP_REFRESH: begin
            r_state      <= REF;
            r_bank_valid <= '1;
          end
          default: begin
            r_state      <= IDLE;
            r_bank_valid <= '0;
            if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end
        endcase
      end else if (w_hs || w_ref_done) begin
        r_state      <= IDLE;
        r_bank_valid <= '0;
      end else if (r_state == REF) begin
        // Refresh stays pending on each bank until that bank alone has acked.
        r_ack_mask   <= r_ack_mask | w_acks;
        r_bank_valid <= r_bank_valid & ~i_bank_ready;
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - self-checking bench for cmd_dispatcher
`timescale 1ns/1ps
module tb_cmd_dispatcher;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_fifo_data;
  logic        i_fifo_empty;
  logic        o_fifo_rd_en;
  logic [NB-1:0] o_bank_valid;
  logic [31:0] o_bank_cmd;
  logic [NB-1:0] i_bank_ready;
  logic        o_busy;
  logic [15:0] o_issue_cnt;
  logic [7:0]  o_drop_cnt;

  always #5 clk = ~clk;

  cmd_dispatcher #(.NUM_BANK(NB), .CMD_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_bank_valid (o_bank_valid),
    .o_bank_cmd   (o_bank_cmd),
    .i_bank_ready (i_bank_ready),
    .o_busy       (o_busy),
    .o_issue_cnt  (o_issue_cnt),
    .o_drop_cnt   (o_drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [3:0]  ready;

  // Reference model: one outstanding job with a set of banks still owed a handshake.
  bit          m_job;
  bit          m_rw;
  logic [3:0]  m_out;
  logic [31:0] m_cmd;
  int          m_issue;
  int          m_drop;

  logic [3:0]  obs_valid;
  logic        obs_rd;
  logic        obs_busy;
  logic [31:0] obs_cmd;

  typedef struct {
    logic [1:0] op;
    logic [1:0] bank;
    logic [3:0] rdy;
    logic [3:0] exp_valid;
    logic       exp_busy;
    int         exp_issue_d;
    int         exp_drop_d;
  } vec_t;

  vec_t vecs[8];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(int op, int bank, int id);
    logic [31:0] c;
    c = $urandom;
    c[31:30] = op[1:0];
    c[29:28] = bank[1:0];
    c[3:0]   = id[3:0];
    return c;
  endfunction

  task automatic model_reset();
    m_job = 0; m_rw = 0; m_out = '0; m_cmd = '0; m_issue = 0; m_drop = 0;
  endtask

  task automatic step();
    bit fin;
    bit exp_rd;
    @(negedge clk);
    i_bank_ready = ready;
    i_fifo_empty = (q.size() == 0);
    i_fifo_data  = (q.size() == 0) ? $urandom : q[0];
    #1;
    obs_valid = o_bank_valid;
    obs_rd    = o_fifo_rd_en;
    obs_busy  = o_busy;
    obs_cmd   = o_bank_cmd;
    fin    = m_job && ((m_out & ~ready) == 4'b0);
    exp_rd = (q.size() != 0) && (!m_job || fin);
    check("bank_valid", obs_valid, m_out);
    check("fifo_rd_en", obs_rd, exp_rd);
    check("busy", obs_busy, m_job);
    check("bank_cmd", obs_cmd, m_cmd);
    check("issue_cnt", o_issue_cnt, m_issue);
    check("drop_cnt", o_drop_cnt, m_drop);
    if (fin) begin
      if (m_rw) m_issue = (m_issue + 1) % 65536;
      m_job = 0;
      m_out = '0;
    end else begin
      m_out = m_out & ~ready;
    end
    if (exp_rd) begin
      m_cmd = q[0];
      case (m_cmd[31:30])
        2'b00:   begin if (m_drop < 255) m_drop++; end
        2'b11:   begin m_job = 1; m_rw = 0; m_out = 4'hF; end
        default: begin m_job = 1; m_rw = 1; m_out = 4'b0001 << m_cmd[29:28]; end
      endcase
    end
    if (obs_rd && q.size() != 0) void'(q.pop_front());
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while ((m_job || q.size() != 0) && n < bound) begin
      step();
      n++;
    end
    check("drain_timeout", (m_job || q.size() != 0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_i;
    int base_d;
    bit saw_valid;
    logic [31:0] c;

    vecs[0] = '{2'b01, 2'd0, 4'hF, 4'b0001, 1'b1, 1, 0};
    vecs[1] = '{2'b01, 2'd1, 4'hF, 4'b0010, 1'b1, 1, 0};
    vecs[2] = '{2'b10, 2'd2, 4'hF, 4'b0100, 1'b1, 1, 0};
    vecs[3] = '{2'b10, 2'd3, 4'b1000, 4'b1000, 1'b1, 1, 0};
    vecs[4] = '{2'b00, 2'd1, 4'hF, 4'b0000, 1'b0, 0, 1};
    vecs[5] = '{2'b11, 2'd0, 4'hF, 4'b1111, 1'b1, 0, 0};
    vecs[6] = '{2'b01, 2'd3, 4'hF, 4'b1000, 1'b1, 1, 0};
    vecs[7] = '{2'b00, 2'd2, 4'hF, 4'b0000, 1'b0, 0, 1};

    rst_n = 1'b0;
    ready = '0;
    i_bank_ready = 4'hF;
    i_fifo_empty = 1'b0;
    i_fifo_data  = mk(1, 2, 3);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", o_fifo_rd_en, 0);
    check("rst_valid", o_bank_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cmd", o_bank_cmd, 0);
    check("rst_issue", o_issue_cnt, 0);
    check("rst_drop", o_drop_cnt, 0);
    @(negedge clk);
    i_fifo_empty = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      base_i = m_issue;
      base_d = m_drop;
      ready = vecs[i].rdy;
      q.push_back(mk(vecs[i].op, vecs[i].bank, i));
      step();
      step();
      check("vec_valid", obs_valid, vecs[i].exp_valid);
      check("vec_busy", obs_busy, vecs[i].exp_busy);
      drain(10);
      step();
      check("vec_issue", o_issue_cnt, base_i + vecs[i].exp_issue_d);
      check("vec_drop", o_drop_cnt, base_d + vecs[i].exp_drop_d);
    end

    // Single READ to bank 2
    base_i = m_issue;
    ready = 4'b0100;
    q.push_back(mk(1, 2, 3));
    step();
    check("read1_rd_en", obs_rd, 1);
    step();
    check("read1_valid", obs_valid, 4'b0100);
    step();
    check("read1_idle", obs_busy, 0);
    check("read1_issue", o_issue_cnt, base_i + 1);

    // Back-to-back WRITEs with no bubble
    base_i = m_issue;
    ready = 4'hF;
    for (int b = 0; b < 4; b++) q.push_back(mk(2, b, b));
    step();
    for (int b = 0; b < 4; b++) begin
      step();
      check("b2b_valid", obs_valid, 4'b0001 << b);
      check("b2b_rd_en", obs_rd, (b < 3));
    end
    step();
    check("b2b_idle", obs_busy, 0);
    check("b2b_issue", o_issue_cnt, base_i + 4);

    // Back-pressure holds the command and blocks further pops
    base_i = m_issue;
    ready = 4'b0000;
    c = mk(1, 1, 7);
    q.push_back(c);
    q.push_back(mk(0, 0, 0));
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", obs_valid, 4'b0010);
      check("stall_cmd", obs_cmd, c);
      check("stall_rd_en", obs_rd, 0);
    end
    ready = 4'b0010;
    step();
    check("stall_release_valid", obs_valid, 4'b0010);
    check("stall_release_rd", obs_rd, 1);
    ready = 4'b0000;
    step();
    check("stall_issue", o_issue_cnt, base_i + 1);
    check("stall_idle", obs_busy, 0);

    // REFRESH with staggered acks
    base_i = m_issue;
    ready = 4'b0000;
    q.push_back(mk(3, 0, 0));
    step();
    ready = 4'b0001;
    step();
    check("ref_valid0", obs_valid, 4'b1111);
    ready = 4'b0100;
    step();
    check("ref_valid1", obs_valid, 4'b1110);
    ready = 4'b1010;
    step();
    check("ref_valid2", obs_valid, 4'b1010);
    ready = 4'b0000;
    step();
    check("ref_valid3", obs_valid, 4'b0000);
    check("ref_idle", obs_busy, 0);
    check("ref_issue", o_issue_cnt, base_i);

    // Random traffic against the model
    for (int cy = 0; cy < 1500; cy++) begin
      if (q.size() < 6 && $urandom_range(0, 2) != 0)
        q.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3), cy));
      ready = 4'($urandom);
      step();
    end
    ready = 4'hF;
    drain(60);

    // NOP flood saturates the drop counter
    ready = 4'hF;
    saw_valid = 0;
    for (int k = 0; k < 260; k++) q.push_back(mk(0, $urandom_range(0, 3), k));
    for (int k = 0; k < 400 && (q.size() != 0 || m_job); k++) begin
      step();
      if (obs_valid != 4'b0) saw_valid = 1;
    end
    check("nop_no_valid", saw_valid, 0);
    step();
    check("nop_drop_sat", o_drop_cnt, 255);

    // Asynchronous reset mid-ISSUE
    ready = 4'b0000;
    q.push_back(mk(1, 3, 5));
    step();
    step();
    check("arst_pre_valid", obs_valid, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", o_bank_valid, 0);
    check("arst_rd_en", o_fifo_rd_en, 0);
    check("arst_busy", o_busy, 0);
    check("arst_cmd", o_bank_cmd, 0);
    check("arst_issue", o_issue_cnt, 0);
    check("arst_drop", o_drop_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("arst_stay_idle", obs_busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
